uart_rx_64: RTL
===============

Name: uart_rx_64

Overview:
- Serial front end of the course-design top. Receives eight 8N1 UART bytes on one rx line and assembles them into one 64-bit word.
- Presents the word with a one-cycle valid strobe to the downstream 64-bit processing stage, which consumes data_in_64.
- Mirrors the word-level handoff that the transmit side uses toward the PC.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division; default 434.
- TIMEOUT_BITS, 20, idle gap in bit times that aborts a partially received word.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous UART line; idles high.
- data_out_64  out  64  last complete word. First received byte sits in [63:56], last in [7:0].
- data_valid  out  1  one-cycle pulse when data_out_64 updates.
- byte_cnt  out  3  number of bytes of the current word received so far (0..7).
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- timeout_err  out  1  one-cycle pulse on an inter-byte timeout.

Behaviour:
- Reset (rst=1 on a clock edge):
  - rx synchronizer stages = 1; FSM = IDLE; counters = 0.
  - data_out_64 = 0; data_valid, frame_err, timeout_err = 0; byte_cnt = 0.
  - Reset mid-byte or mid-word discards all partial data.
- rx passes through a 2-FF synchronizer. All decisions use the synchronized signal rx_s.
- FSM states:
  - IDLE: a falling edge on rx_s (previous 1, current 0) -> START, bit counter cleared.
  - START: count to CLKS_PER_BIT/2 - 1 (216), then sample rx_s.
    - 0 -> DATA, bit counter cleared.
    - 1 -> IDLE (glitch, no error, nothing recorded).
  - DATA: sample rx_s every CLKS_PER_BIT cycles, 8 samples, LSB first into the shift register. After the 8th sample -> STOP.
  - STOP: sample rx_s after CLKS_PER_BIT cycles.
    - 1 -> byte accepted; the byte is written into slot byte_cnt (slot 0 = [63:56]); byte_cnt increments; -> IDLE.
    - 0 -> frame_err pulses; the whole partial word is discarded; byte_cnt = 0; -> IDLE.
  - IDLE is re-entered at mid stop bit, so back-to-back bytes with zero gap are received.
- Word completion: when the 8th byte is accepted, the next cycle data_out_64 takes the assembled word, data_valid = 1 for exactly one cycle, and byte_cnt returns to 0.
  - data_out_64 holds its value until the next complete word or reset.
- Latency: data_valid rises 2 (synchronizer) + 9.5*CLKS_PER_BIT + 2 cycles after the start-bit falling edge of byte 8, within ±1 cycle.
- Timeout:
  - In IDLE with byte_cnt != 0, an idle counter increments each cycle and clears on any falling edge.
  - When it reaches TIMEOUT_BITS*CLKS_PER_BIT: timeout_err pulses, byte_cnt = 0, partial data discarded.
  - With byte_cnt == 0 the idle counter is held at 0.
- Simultaneous events:
  - frame_err and timeout_err never assert in the same cycle.
  - A falling edge in the same cycle the timeout expires: the timeout wins, and the new byte starts a fresh word.
- rx held low indefinitely (break): the first byte ends in frame_err. No new start is detected until rx_s returns high and falls again.
- Counter widths are sized for TIMEOUT_BITS*CLKS_PER_BIT; no wrap-around is reachable.

Test Plan:
- Bytes 81 A3 4D 6F F6 B2 C5 81 at 115200 baud, 1 bit-time gaps -> one data_valid pulse, data_out_64 = 64'h81A34D6FF6B2C581, no error pulses.
- Same word followed immediately by 44 23 3E 79 47 94 27 F7 with zero gaps -> two data_valid pulses; final data_out_64 = 64'h44233E79479427F7.
- Third byte's stop bit driven 0 -> frame_err pulse, byte_cnt returns to 0, no data_valid. Then 8 clean bytes AA..AA -> data_out_64 = 64'hAAAA_AAAA_AAAA_AAAA.
- 3 bytes sent, then rx idle for 21 bit times -> timeout_err pulse at 20 bit times, byte_cnt = 0. Then a full word -> correct assembly from byte 0.
- 100-cycle low glitch on an idle rx -> no state change beyond START, no outputs toggle, byte_cnt unchanged.
- rst pulsed during the 5th byte -> all outputs 0 on the next cycle. A subsequent full word 0123456789ABCDEF is received correctly.

Source files
------------

// File: rtl/uart_rx_64.sv
// 8N1 UART receiver that packs eight consecutive bytes into one 64-bit word
// (first byte in [63:56]) and strobes data_valid when the word is complete.
module uart_rx_64 #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [63:0] data_out_64,
  output logic        data_valid,
  output logic [2:0]  byte_cnt,
  output logic        frame_err,
  output logic        timeout_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(TO_CYCLES + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic             rx_prev_q, rx_prev_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [63:0]      word_q, word_d;
  logic [2:0]       byte_cnt_q, byte_cnt_d;
  logic [63:0]      data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             timeout_err_q, timeout_err_d;
  logic             fall;

  always_comb begin
    state_d       = state_q;
    rx_meta_d     = rx;
    rx_s_d        = rx_meta_q;
    rx_prev_d     = rx_s_q;
    clk_cnt_d     = clk_cnt_q;
    idle_cnt_d    = '0;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    word_d        = word_q;
    byte_cnt_d    = byte_cnt_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    fall          = rx_prev_q & ~rx_s_q;

    case (state_q)
      IDLE: begin
        if (byte_cnt_q != 3'd0) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
          if (idle_cnt_q == TO_LAST) begin
            timeout_err_d = 1'b1;
            byte_cnt_d    = 3'd0;
            word_d        = '0;
            idle_cnt_d    = '0;
          end
        end
        // A start edge coinciding with timeout expiry still begins a byte,
        // which then lands in slot 0 of a fresh word.
        if (fall) begin
          idle_cnt_d = '0;
          clk_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = 3'd0;
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (rx_s_q) begin
            word_d     = word_q | ({56'd0, shift_q} << {3'd7 - byte_cnt_q, 3'b000});
            byte_cnt_d = byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'd7) begin
              data_out_d   = word_q | {56'd0, shift_q};
              data_valid_d = 1'b1;
              word_d       = '0;
            end
          end else begin
            frame_err_d = 1'b1;
            byte_cnt_d  = 3'd0;
            word_d      = '0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (rst) begin
      state_q       <= IDLE;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      clk_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      bit_cnt_q     <= 3'd0;
      word_q        <= '0;
      byte_cnt_q    <= 3'd0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= rx_meta_d;
      rx_s_q        <= rx_s_d;
      rx_prev_q     <= rx_prev_d;
      clk_cnt_q     <= clk_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      word_q        <= word_d;
      byte_cnt_q    <= byte_cnt_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign data_out_64 = data_out_q;
  assign data_valid  = data_valid_q;
  assign byte_cnt    = byte_cnt_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;

endmodule
